// File: rtl/axi_chdr_fanout.sv
// Splits each input beat into NUM_CH components and sends each one out on its own AXI-Stream.
// Every output channel gets the packet's CHDR header, with the SIDs rewritten for that channel.

module axi_chdr_fanout_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    // A push while full is refused even if a pop happens in the same cycle.
    assign full_o    = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign dout_o    = mem_q[rd_q];

    // Compute the next pointers and the next occupancy.
    always_comb begin
        wr_d  = do_push_s ? wr_q + AW'(1) : wr_q;
        rd_d  = do_pop_s  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array; it is not reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_q] <= din_i;
        end else begin
            mem_q[wr_q] <= mem_q[wr_q];
        end
    end
endmodule

module axi_chdr_fanout #(
    parameter int WIDTH         = 16,
    parameter int NUM_CH        = 2,
    parameter int FIFO_SIZE     = 5,
    parameter int HDR_FIFO_SIZE = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [NUM_CH-1:0]       enable_mask,
    input  logic [16*NUM_CH-1:0]    next_dst,
    input  logic [NUM_CH*WIDTH-1:0] i_tdata,
    input  logic [127:0]            i_tuser,
    input  logic                    i_tlast,
    input  logic                    i_tvalid,
    output logic                    i_tready,
    output logic [NUM_CH*WIDTH-1:0] o_tdata,
    output logic [128*NUM_CH-1:0]   o_tuser,
    output logic [NUM_CH-1:0]       o_tlast,
    output logic [NUM_CH-1:0]       o_tvalid,
    input  logic [NUM_CH-1:0]       o_tready
);
    logic              flush_s, accept_s, room_s;
    logic              sop_q, sop_d;
    logic [NUM_CH-1:0] mask_q, mask_d, active_s;
    logic [NUM_CH-1:0] dfull_s, dempty_s, hfull_s, hempty_s;
    logic [NUM_CH-1:0] dpush_s, hpush_s, dpop_s, hpop_s;

    assign flush_s  = reset | clear;
    // The live mask applies only at SOP; later beats of the packet use the mask latched at SOP.
    assign active_s = sop_q ? enable_mask : mask_q;
    assign i_tready = room_s & ~flush_s;
    assign accept_s = i_tvalid & i_tready;
    assign dpush_s  = accept_s ? active_s : '0;
    assign hpush_s  = (accept_s & sop_q) ? active_s : '0;

    // Check that every active channel has room for this beat.
    always_comb begin
        room_s = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (active_s[c] && (dfull_s[c] || (sop_q && hfull_s[c]))) begin
                room_s = 1'b0;
            end else begin
                room_s = room_s;
            end
        end
    end

    // Next-state logic for the SOP flag and the latched mask.
    always_comb begin
        sop_d  = sop_q;
        mask_d = mask_q;
        if (accept_s) begin
            sop_d  = i_tlast;
            mask_d = sop_q ? enable_mask : mask_q;
        end else begin
            sop_d  = sop_q;
            mask_d = mask_q;
        end
    end

    // SOP flag and latched-mask registers.
    always_ff @(posedge clk) begin
        if (flush_s) begin
            sop_q  <= 1'b1;
            mask_q <= '0;
        end else begin
            sop_q  <= sop_d;
            mask_q <= mask_d;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [3:0] CH_ID = 4'(c);

        logic [WIDTH:0] dhead_s;
        logic [127:0]   hdr_s, hhead_s;

        // The new source SID takes the upper 12 bits of the old destination SID plus the channel
        // number; the new destination SID comes from next_dst.
        always_comb begin
            hdr_s         = i_tuser;
            hdr_s[95:80]  = {i_tuser[79:68], CH_ID};
            hdr_s[79:64]  = next_dst[16*c +: 16];
        end

        axi_chdr_fanout_fifo #(.DW(WIDTH + 1), .AW(FIFO_SIZE)) u_dfifo (
            .clk     (clk),
            .flush_i (flush_s),
            .push_i  (dpush_s[c]),
            .din_i   ({i_tdata[WIDTH*(NUM_CH-c)-1 -: WIDTH], i_tlast}),
            .pop_i   (dpop_s[c]),
            .dout_o  (dhead_s),
            .full_o  (dfull_s[c]),
            .empty_o (dempty_s[c])
        );

        axi_chdr_fanout_fifo #(.DW(128), .AW(HDR_FIFO_SIZE)) u_hfifo (
            .clk     (clk),
            .flush_i (flush_s),
            .push_i  (hpush_s[c]),
            .din_i   (hdr_s),
            .pop_i   (hpop_s[c]),
            .dout_o  (hhead_s),
            .full_o  (hfull_s[c]),
            .empty_o (hempty_s[c])
        );

        // The header stays at the head of its FIFO until the packet's last beat leaves.
        assign o_tvalid[c]              = ~dempty_s[c] & ~hempty_s[c] & ~flush_s;
        assign dpop_s[c]                = o_tvalid[c] & o_tready[c];
        assign hpop_s[c]                = dpop_s[c] & dhead_s[0];
        assign o_tdata[WIDTH*c +: WIDTH] = dhead_s[WIDTH:1];
        assign o_tlast[c]               = dhead_s[0];
        assign o_tuser[128*c +: 128]    = hhead_s;
    end
endmodule

// File: tb/tb_axi_chdr_fanout.sv
// Directed bench for axi_chdr_fanout (2 channels, 4-deep data FIFOs, 2-deep header FIFOs).
// The stimulus side queues the expected beats per channel; a negedge monitor compares them.

module tb_axi_chdr_fanout;
    logic         clk = 1'b0;
    logic         reset, clear;
    logic [1:0]   enable_mask;
    logic [31:0]  next_dst;
    logic [31:0]  i_tdata;
    logic [127:0] i_tuser;
    logic         i_tlast, i_tvalid, i_tready;
    logic [31:0]  o_tdata;
    logic [255:0] o_tuser;
    logic [1:0]   o_tlast, o_tvalid, o_tready;

    always #5 clk = ~clk;

    axi_chdr_fanout #(.WIDTH(16), .NUM_CH(2), .FIFO_SIZE(2), .HDR_FIFO_SIZE(1)) dut (
        .clk(clk), .reset(reset), .clear(clear), .enable_mask(enable_mask), .next_dst(next_dst),
        .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    int           n_chk = 0;
    int           n_fail = 0;
    logic [144:0] exp_q [2][$];
    logic [144:0] mon_e;
    logic         m_sop;
    logic [1:0]   m_mask;
    int           w;
    logic [127:0] u;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [127:0] munge(input logic [127:0] uu, input int c);
        logic [127:0] r;
        r = uu;
        r[95:80] = {uu[79:68], 4'(c)};
        r[79:64] = (c == 0) ? next_dst[15:0] : next_dst[31:16];
        return r;
    endfunction

    // Drive one beat, wait (bounded) for acceptance, and queue what each active channel should emit.
    task automatic send_beat(input logic [31:0] d, input logic [127:0] uu, input logic l, output int waited);
        logic [1:0] act;
        waited = 0;
        i_tdata = d; i_tuser = uu; i_tlast = l; i_tvalid = 1'b1;
        @(negedge clk);
        while (!i_tready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!i_tready) begin
            chk("accept timeout", 128'(i_tready), 128'(1'b1));
        end else begin
            act = m_sop ? enable_mask : m_mask;
            if (m_sop) m_mask = enable_mask;
            for (int c = 0; c < 2; c++)
                if (act[c]) exp_q[c].push_back({(c == 0) ? d[31:16] : d[15:0], l, munge(uu, c)});
            m_sop = l;
        end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain pending", 128'(exp_q[0].size() + exp_q[1].size()), 128'(0));
        @(posedge clk); #1;
        chk("valid after drain", 128'(o_tvalid), 128'(2'b00));
    endtask

    // Monitor: every beat presented and taken must match the head of that channel's queue.
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (o_tvalid[c]) begin
                if (exp_q[c].size() == 0) begin
                    chk($sformatf("ch%0d spurious valid", c), 128'(o_tvalid[c]), 128'(1'b0));
                end else if (o_tready[c]) begin
                    mon_e = exp_q[c].pop_front();
                    chk($sformatf("ch%0d data", c), 128'(o_tdata[16*c +: 16]), 128'(mon_e[144:129]));
                    chk($sformatf("ch%0d last", c), 128'(o_tlast[c]), 128'(mon_e[128]));
                    chk($sformatf("ch%0d user", c), o_tuser[128*c +: 128], mon_e[127:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; enable_mask = 2'b11; next_dst = {16'h0020, 16'h0010};
        i_tdata = 32'h0; i_tuser = 128'h0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 2'b11;
        m_sop = 1'b1; m_mask = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset o_tvalid", 128'(o_tvalid), 128'(2'b00));
        chk("reset i_tready", 128'(i_tready), 128'(1'b0));
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("i_tready after reset", 128'(i_tready), 128'(1'b1));
        @(posedge clk); #1;

        // Basic 4-beat packet with hand-computed SIDs.
        u = {32'hA000_0004, 32'h0100_0230, 64'h0000_0000_0000_1000};
        chk("valid before accept", 128'(o_tvalid), 128'(2'b00));
        send_beat(32'hAAAA_5555, u, 1'b0, w);
        chk("latency o_tvalid", 128'(o_tvalid), 128'(2'b11));
        chk("o_tdata split", 128'(o_tdata), 128'(32'h5555_AAAA));
        chk("ch0 SID", 128'(o_tuser[95:64]), 128'(32'h0230_0010));
        chk("ch1 SID", 128'(o_tuser[223:192]), 128'(32'h0231_0020));
        for (int i = 1; i < 4; i++) send_beat(32'hAAAA_5555, u, (i == 3), w);
        wait_drain();

        // Stall channel 1 only: its 4-deep FIFO fills, then input stops until it drains.
        o_tready = 2'b01;
        u = {32'hB000_0008, 32'h0200_0340, 64'h0000_0000_0000_2000};
        for (int i = 0; i < 4; i++) begin
            send_beat({16'h1100 + 16'(i), 16'h2200 + 16'(i)}, u, 1'b0, w);
            chk("stall fill no wait", 128'(w), 128'(0));
        end
        i_tdata = 32'h1104_2204; i_tvalid = 1'b1; i_tlast = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall i_tready", 128'(i_tready), 128'(1'b0));
        end
        chk("stall ch0 drained", 128'(o_tvalid), 128'(2'b10));
        @(posedge clk); #1;
        o_tready = 2'b11;
        send_beat(32'h1104_2204, u, 1'b0, w);
        chk("resume wait", 128'(w), 128'(1));
        send_beat(32'h1105_2205, u, 1'b1, w);
        wait_drain();

        // Mask change mid-packet applies from the next packet.
        u = {32'hC000_0010, 32'h0300_0450, 64'h0000_0000_0000_3000};
        send_beat(32'h3000_4000, u, 1'b0, w);
        enable_mask = 2'b01;
        for (int i = 1; i < 8; i++) send_beat({16'h3000 + 16'(i), 16'h4000 + 16'(i)}, u, (i == 7), w);
        u = {32'hC100_0004, 32'h0310_0560, 64'h0000_0000_0000_3100};
        send_beat(32'h5000_6000, u, 1'b0, w);
        chk("mask next pkt valid", 128'(o_tvalid), 128'(2'b01));
        send_beat(32'h5001_6001, u, 1'b1, w);
        wait_drain();

        // Empty mask: beats consumed and discarded.
        enable_mask = 2'b00;
        for (int p = 0; p < 3; p++) begin
            u = {32'hD000_0004, 16'h0400 + 16'(p), 16'h0500, 64'(p)};
            for (int i = 0; i < 2; i++) begin
                send_beat(32'h7777_8888, u, (i == 1), w);
                chk("empty mask no wait", 128'(w), 128'(0));
                chk("empty mask valid", 128'(o_tvalid), 128'(2'b00));
            end
        end

        // Header FIFO (2 deep) limits single-beat packets while outputs are stalled.
        enable_mask = 2'b11;
        o_tready = 2'b00;
        for (int p = 0; p < 2; p++) begin
            u = {32'hE000_0002, 16'h0600 + 16'(p), 16'h0700 + 16'(p * 16), 64'(p + 100)};
            send_beat({16'h9000 + 16'(p), 16'hA000 + 16'(p)}, u, 1'b1, w);
            chk("hdr fill no wait", 128'(w), 128'(0));
        end
        i_tvalid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("hdr full i_tready", 128'(i_tready), 128'(1'b0));
        end
        @(posedge clk); #1;
        o_tready = 2'b11;
        for (int p = 2; p < 20; p++) begin
            u = {32'hE000_0002, 16'h0600 + 16'(p), 16'h0700 + 16'(p * 16), 64'(p + 100)};
            send_beat({16'h9000 + 16'(p), 16'hA000 + 16'(p)}, u, 1'b1, w);
        end
        wait_drain();

        // Reset in the middle of a packet discards it.
        o_tready = 2'b00;
        u = {32'hF000_000C, 32'h0800_0900, 64'h0000_0000_0000_6000};
        send_beat(32'hBB00_CC00, u, 1'b0, w);
        send_beat(32'hBB01_CC01, u, 1'b0, w);
        i_tdata = 32'hBB02_CC02; i_tvalid = 1'b1;
        reset = 1'b1;
        exp_q[0].delete(); exp_q[1].delete();
        m_sop = 1'b1; m_mask = 2'b00;
        @(negedge clk);
        chk("in reset i_tready", 128'(i_tready), 128'(1'b0));
        chk("in reset o_tvalid", 128'(o_tvalid), 128'(2'b00));
        @(posedge clk); #1;
        reset = 1'b0; i_tvalid = 1'b0;
        @(negedge clk);
        chk("post reset empty", 128'(o_tvalid), 128'(2'b00));
        chk("post reset i_tready", 128'(i_tready), 128'(1'b1));
        @(posedge clk); #1;
        o_tready = 2'b11;
        u = {32'hF100_0008, 32'h0A00_0B00, 64'h0000_0000_0000_7000};
        send_beat(32'hDD00_EE00, u, 1'b0, w);
        send_beat(32'hDD01_EE01, u, 1'b1, w);
        wait_drain();

        // Clear behaves like reset.
        o_tready = 2'b00;
        send_beat(32'h1234_5678, u, 1'b0, w);
        clear = 1'b1;
        exp_q[0].delete(); exp_q[1].delete();
        m_sop = 1'b1; m_mask = 2'b00;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("post clear empty", 128'(o_tvalid), 128'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
